alu_nibble_seq: RTL and testbench

Nibble-serial sequencer that drives one combinational 4-bit 74181-style `alu` instance to perform 4·NIBBLES-bit operations. It accepts a wide request over a valid/ready handshake and feeds the ALU one nibble per cycle, LSB first. Between nibbles it chains the active-low carry (`cn_4` → `cn`) and accumulates `a_eq_b`. It returns the wide result over a second valid/ready handshake. It sits between a request source (CPU-side issue logic or a bench driver) and the `alu` DUT, taking the place of a direct `alu_if` connection.

---
 rtl/alu_nibble_seq.sv | 134 +++++++++++++
 tb/tb_alu_nibble_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq
//   Nibble-serial sequencer around one combinational 4-bit 74181-style ALU.
//   A wide request (W = 4*NIBBLES bits) is accepted over req_valid/req_ready.
//   The operands are then fed to the ALU one nibble per cycle, LSB first.
//   The active-low carry is chained from cn_4 back into cn, and a_eq_b is
//   ANDed across all nibbles. The wide result is returned over
//   rsp_valid/rsp_ready.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_s, req_m, req_cn    74181 function select, mode (1=logic), carry-in (active-low)
//   req_a, req_b            W-bit operands
//   rsp_valid/rsp_ready     response handshake
//   rsp_f                   W-bit result
//   rsp_cn_out              carry out of the MSB nibble (active-low)
//   rsp_a_eq_b              AND of a_eq_b over all nibbles
//   alu_s/m/cn/a/b          registered drive to the ALU
//   alu_f/cn_4/a_eq_b       combinational return from the ALU
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_s,
  input  logic                 req_m,
  input  logic                 req_cn,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_f,
  output logic                 rsp_cn_out,
  output logic                 rsp_a_eq_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cn,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cn_4,
  input  logic                 alu_a_eq_b
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [3:0]    op_s;
  logic          op_m;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res;
  logic          cr;
  logic          eq_acc;
  logic [IW-1:0] idx;

  logic [W-1:0]  res_nx;
  logic          last;

  // The new nibble enters at the MSB end, so after NIBBLES shifts
  // nibble 0 sits at bits [3:0].
  always_comb begin
    res_nx           = res >> 4;
    res_nx[W-1 -: 4] = alu_f;
  end

  assign last = (idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_s   <= '0;
      op_m   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cr     <= 1'b1;
      eq_acc <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_s   <= req_s;
            op_m   <= req_m;
            a_sh   <= req_a;
            b_sh   <= req_b;
            cr     <= req_cn;
            eq_acc <= 1'b1;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          res    <= res_nx;
          cr     <= alu_cn_4;
          eq_acc <= eq_acc & alu_a_eq_b;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          // idx stops at NIBBLES-1 rather than wrapping on the final nibble
          if (last) begin
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == DONE);
  assign rsp_f      = res;
  assign rsp_cn_out = cr;
  assign rsp_a_eq_b = eq_acc;

  assign alu_s  = op_s;
  assign alu_m  = op_m;
  assign alu_cn = cr;
  assign alu_a  = a_sh[3:0];
  assign alu_b  = b_sh[3:0];

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq
//   Bench for alu_nibble_seq (NIBBLES=4). A 4-bit 74181 model stands in for
//   the ALU. Expected wide results come from a whole-word model: one W-bit
//   addition for arithmetic mode, one bitwise table for logic mode.
module tb_alu_nibble_seq;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid, req_ready;
  logic [3:0]   req_s;
  logic         req_m, req_cn;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_f;
  logic         rsp_cn_out, rsp_a_eq_b;
  logic [3:0]   alu_s, alu_a, alu_b, alu_f;
  logic         alu_m, alu_cn, alu_cn_4, alu_a_eq_b;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_m(req_m), .req_cn(req_cn),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_cn_out(rsp_cn_out), .rsp_a_eq_b(rsp_a_eq_b),
    .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_cn_4(alu_cn_4), .alu_a_eq_b(alu_a_eq_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 74181 active-high data: arithmetic F = X plus Y plus carry.
  function automatic logic [15:0] fx(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    return a | (s[0] ? b : 16'h0) | (s[1] ? ~b : 16'h0);
  endfunction
  function automatic logic [15:0] fy(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    return (s[2] ? (a & ~b) : 16'h0) | (s[3] ? (a & b) : 16'h0);
  endfunction
  function automatic logic [15:0] flog(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      4'd0:  return ~a;
      4'd1:  return ~(a | b);
      4'd2:  return ~a & b;
      4'd3:  return 16'h0000;
      4'd4:  return ~(a & b);
      4'd5:  return ~b;
      4'd6:  return a ^ b;
      4'd7:  return a & ~b;
      4'd8:  return ~a | b;
      4'd9:  return ~(a ^ b);
      4'd10: return b;
      4'd11: return a & b;
      4'd12: return 16'hFFFF;
      4'd13: return a | ~b;
      4'd14: return a | b;
      default: return a;
    endcase
  endfunction

  // Combinational 4-bit ALU stand-in
  logic [15:0] ax, bx, xv, yv, lv;
  logic [4:0]  s5;
  always_comb begin
    ax         = {12'h000, alu_a};
    bx         = {12'h000, alu_b};
    xv         = fx(alu_s, ax, bx);
    yv         = fy(alu_s, ax, bx);
    lv         = flog(alu_s, ax, bx);
    s5         = {1'b0, xv[3:0]} + {1'b0, yv[3:0]} + {4'b0000, ~alu_cn};
    alu_f      = alu_m ? lv[3:0] : s5[3:0];
    alu_cn_4   = ~s5[4];
    alu_a_eq_b = (alu_f == 4'hF);
  end

  // Whole-word reference model
  bit           busy = 1'b0;
  int           cnt = 0;
  int           accepts = 0;
  logic [3:0]   e_s;
  logic         e_m, e_cn, e_co, e_eq;
  logic [W-1:0] e_a, e_b, e_f;

  task automatic model_op(input logic [3:0] s, input logic m, input logic cn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] f, output logic co, output logic eq);
    logic [W:0] sum;
    sum = {1'b0, fx(s, a, b)} + {1'b0, fy(s, a, b)} + {16'h0000, ~cn};
    f   = m ? flog(s, a, b) : sum[W-1:0];
    co  = ~sum[W];
    eq  = (f == 16'hFFFF);
  endtask

  // Active-low carry entering nibble k: carry out of the low 4k bits.
  function automatic logic cin_at(input int k);
    logic [W:0] mask, p;
    if (k == 0) return e_cn;
    mask = (17'h1 << (4 * k)) - 17'h1;
    p = ({1'b0, fx(e_s, e_a, e_b)} & mask) + ({1'b0, fy(e_s, e_a, e_b)} & mask) + {16'h0000, ~e_cn};
    return ~p[4 * k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0;
      cnt  = 0;
    end else if (!busy) begin
      if (req_valid) begin
        busy = 1'b1;
        cnt  = 0;
        e_s = req_s; e_m = req_m; e_cn = req_cn; e_a = req_a; e_b = req_b;
        model_op(req_s, req_m, req_cn, req_a, req_b, e_f, e_co, e_eq);
        accepts++;
      end
    end else if (cnt < N) begin
      cnt++;
    end else if (rsp_ready) begin
      busy = 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_f", rsp_f, 0);
      chk("rst_rsp_cn_out", rsp_cn_out, 1);
      chk("rst_rsp_a_eq_b", rsp_a_eq_b, 0);
      chk("rst_alu_s", alu_s, 0);
      chk("rst_alu_m", alu_m, 0);
      chk("rst_alu_cn", alu_cn, 1);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
    end else begin
      chk("req_ready", req_ready, !busy);
      chk("rsp_valid", rsp_valid, busy && cnt == N);
      if (busy && cnt < N) begin
        chk("alu_a", alu_a, e_a[4*cnt +: 4]);
        chk("alu_b", alu_b, e_b[4*cnt +: 4]);
        chk("alu_s", alu_s, e_s);
        chk("alu_m", alu_m, e_m);
        if (!e_m) chk("alu_cn", alu_cn, cin_at(cnt));
      end
      if (busy && cnt == N) begin
        chk("rsp_f", rsp_f, e_f);
        chk("rsp_a_eq_b", rsp_a_eq_b, e_eq);
        if (!e_m) chk("rsp_cn_out", rsp_cn_out, e_co);
      end
    end
  end

  task automatic wait_flag(input string nm, input bit want_ready);
    int t = 0;
    while (((want_ready ? req_ready : rsp_valid) !== 1'b1) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic do_op(input logic [3:0] s, input logic m, input logic cn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                       output logic [W-1:0] f, output logic co, output logic eq,
                       output logic [3:0] seq);
    @(negedge clk);
    req_s = s; req_m = m; req_cn = cn; req_a = a; req_b = b;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    wait_flag("accept", 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      seq[i] = alu_cn;
      @(negedge clk);
    end
    chk("latency", rsp_valid, 1);
    wait_flag("rsp", 1'b0);
    f = rsp_f; co = rsp_cn_out; eq = rsp_a_eq_b;
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] f, f0, ra, rb;
    logic         co, eq;
    logic [3:0]   seq;
    int           acc0;

    req_valid = 1'b0; rsp_ready = 1'b0;
    req_s = '0; req_m = 1'b0; req_cn = 1'b1; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_op(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 0, f, co, eq, seq);
    chk("add_f", f, 16'h2233);
    chk("add_co", co, 1);

    do_op(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1, f, co, eq, seq);
    chk("ripple_f", f, 16'h0000);
    chk("ripple_co", co, 0);
    chk("ripple_cn_seq", seq, 4'b0001);

    do_op(4'b0110, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 0, f, co, eq, seq);
    chk("cmp_eq_f", f, 16'hFFFF);
    chk("cmp_eq", eq, 1);
    do_op(4'b0110, 1'b0, 1'b1, 16'hA000, 16'hB000, 0, f, co, eq, seq);
    chk("cmp_ne", eq, 0);

    do_op(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 2, f, co, eq, seq);
    chk("xor_f", f, 16'h0FF0);

    // req_valid held throughout, response stalled for 5 DONE cycles
    @(negedge clk);
    req_s = 4'b1001; req_m = 1'b0; req_cn = 1'b1; req_a = 16'h0005; req_b = 16'h0003;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    acc0 = accepts;
    wait_flag("hs_rsp", 1'b0);
    f0 = rsp_f;
    chk("hs_f", f0, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hs_f_stable", rsp_f, f0);
      chk("hs_valid_stable", rsp_valid, 1);
      chk("hs_req_ready_low", req_ready, 0);
      chk("hs_one_accept", accepts, acc0 + 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hs_idle_ready", req_ready, 1);
    chk("hs_not_yet", accepts, acc0 + 1);
    @(negedge clk);
    chk("hs_second_accept", accepts, acc0 + 2);
    chk("hs_busy_again", req_ready, 0);
    req_valid = 1'b0;
    wait_flag("hs_rsp2", 1'b0);
    chk("hs_f2", rsp_f, 16'h0008);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset two cycles into RUN
    @(negedge clk);
    req_s = 4'b1001; req_m = 1'b0; req_cn = 1'b1; req_a = 16'h7777; req_b = 16'h1111;
    req_valid = 1'b1;
    wait_flag("rr_accept", 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_req_ready", req_ready, 1);
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_rsp_f", rsp_f, 0);
    chk("rr_rsp_cn_out", rsp_cn_out, 1);
    chk("rr_alu_cn", alu_cn, 1);
    chk("rr_alu_a", alu_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rr_no_rsp", rsp_valid, 0);
    do_op(4'b1001, 1'b0, 1'b1, 16'h0001, 16'h0001, 0, f, co, eq, seq);
    chk("rr_add_f", f, 16'h0002);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      do_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ra, rb, $urandom_range(0, 3), f, co, eq, seq);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
